vec_issue_ctrl: RTL and testbench

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

---
 rtl/vec_de_csr_defs.sv | 47 ++++
 rtl/vec_ctrl_decode.sv | 36 +++
 rtl/vec_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_de_csr_defs.sv
// Shared vector decode/CSR definitions: opcodes, funct3 codes, load addressing modes
// and the issue-controller state encoding.
package vec_de_csr_defs;

    typedef enum logic [6:0] {
        OP_V       = 7'b1010111,
        OP_LOAD_FP = 7'b0000111
    } v_opcode_e;

    typedef enum logic [2:0] {
        F3_OPIVV = 3'b000,
        F3_OPFVV = 3'b001,
        F3_OPMVV = 3'b010,
        F3_OPIVI = 3'b011,
        F3_OPIVX = 3'b100,
        F3_OPFVF = 3'b101,
        F3_OPMVX = 3'b110,
        F3_OPCFG = 3'b111
    } v_func3_e;

    localparam logic [2:0] VSET_FUNCT3 = F3_OPCFG;

    // Vector load element widths share the LOAD-FP opcode with scalar FP loads.
    localparam logic [2:0] LD_W8  = 3'b000;
    localparam logic [2:0] LD_W16 = 3'b101;
    localparam logic [2:0] LD_W32 = 3'b110;
    localparam logic [2:0] LD_W64 = 3'b111;

    typedef enum logic [1:0] {
        MOP_UNIT      = 2'b00,
        MOP_IDX_UNORD = 2'b01,
        MOP_STRIDED   = 2'b10,
        MOP_IDX_ORD   = 2'b11
    } v_mop_e;

    typedef enum logic [1:0] {
        IDLE,
        CONF,
        LD_REQ,
        LD_WAIT
    } ctrl_state_e;

    function automatic logic is_load_width(input logic [2:0] f3);
        return (f3 == LD_W8) || (f3 == LD_W16) || (f3 == LD_W32) || (f3 == LD_W64);
    endfunction

endpackage

// File: rtl/vec_ctrl_decode.sv
// Combinational field decode of a vector instruction word: classifies vset*/vector
// loads and extracts the fields that steer the operand selects.
module vec_ctrl_decode
    import vec_de_csr_defs::*;
(
    input  logic [31:0] inst,
    output logic        is_vset,
    output logic        is_load,
    output logic        is_vsetivli,
    output logic        is_vsetvl,
    output logic        x0_pair,
    output v_mop_e      mop
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rd     = inst[11:7];

    // Immediate/vtype and nf/lumop fields do not influence the control path.
    assign unused_fields = ^{inst[29:28], inst[25:20]};

    assign is_vset     = (opcode == OP_V) && (funct3 == VSET_FUNCT3);
    assign is_load     = (opcode == OP_LOAD_FP) && is_load_width(funct3);
    assign is_vsetivli = (inst[31:30] == 2'b11);
    assign is_vsetvl   = (inst[31:30] == 2'b10);
    assign x0_pair     = (rs1 == 5'd0) && (rd == 5'd0);
    assign mop         = v_mop_e'(inst[27:26]);

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: accepts one instruction at a time, sequences vset* CSR
// writes and vector load requests, and watches for loads that never complete.
module vec_issue_ctrl
    import vec_de_csr_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int TMO_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] vec_inst,
    input  logic            inst_valid,
    output logic            inst_ready,
    output logic            vl_sel,
    output logic            vtype_sel,
    output logic            rs1rd_de,
    output logic            lumop_sel,
    output logic            rs1_sel,
    output logic            vs2_sel,
    output logic            csrwr_en,
    output logic            ld_req,
    input  logic            ld_done,
    output logic            busy,
    output logic            illegal_inst,
    output logic            timeout_err
);

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
    // The timeout fires on the edge where the count would reach TMO_MAX.
    localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - TMO_W'(1);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic [XLEN-1:0]  inst_q;
    logic [TMO_W-1:0] wd_cnt;
    logic             accept;
    logic             illegal_next;
    logic             timeout_next;

    logic   in_vset;
    logic   in_load;
    logic   unused_in_ivli;
    logic   unused_in_vsetvl;
    logic   unused_in_x0;
    v_mop_e unused_in_mop;

    logic   q_ivli;
    logic   q_vsetvl;
    logic   q_x0;
    logic   unused_q_vset;
    logic   unused_q_load;
    v_mop_e q_mop;

    assign inst_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = inst_valid && inst_ready;

    // Dispatch classifies the word being accepted; select outputs use the latched copy.
    vec_ctrl_decode u_dec_in (
        .inst        (vec_inst[31:0]),
        .is_vset     (in_vset),
        .is_load     (in_load),
        .is_vsetivli (unused_in_ivli),
        .is_vsetvl   (unused_in_vsetvl),
        .x0_pair     (unused_in_x0),
        .mop         (unused_in_mop)
    );

    vec_ctrl_decode u_dec_q (
        .inst        (inst_q[31:0]),
        .is_vset     (unused_q_vset),
        .is_load     (unused_q_load),
        .is_vsetivli (q_ivli),
        .is_vsetvl   (q_vsetvl),
        .x0_pair     (q_x0),
        .mop         (q_mop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            inst_q       <= '0;
            wd_cnt       <= '0;
            illegal_inst <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            illegal_inst <= illegal_next;
            timeout_err  <= timeout_next;
            if (accept) begin
                inst_q <= vec_inst;
            end
            if (state == LD_REQ) begin
                wd_cnt <= '0;
            end else if ((state == LD_WAIT) && !ld_done) begin
                wd_cnt <= wd_cnt + TMO_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state;
        illegal_next = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid) begin
                    if (in_vset) begin
                        state_next = CONF;
                    end else if (in_load) begin
                        state_next = LD_REQ;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            CONF:   state_next = IDLE;
            LD_REQ: state_next = LD_WAIT;
            LD_WAIT: begin
                // Completion beats the watchdog when both land in the same cycle.
                if (ld_done) begin
                    state_next = IDLE;
                end else if (wd_cnt == TMO_PRE) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vl_sel    = 1'b0;
        vtype_sel = 1'b0;
        rs1rd_de  = 1'b1;
        lumop_sel = 1'b0;
        rs1_sel   = 1'b1;
        vs2_sel   = 1'b0;
        csrwr_en  = 1'b0;
        ld_req    = 1'b0;
        case (state)
            CONF: begin
                csrwr_en = 1'b1;
                if (q_ivli) begin
                    vl_sel    = 1'b1;
                    vtype_sel = 1'b1;
                    rs1rd_de  = 1'b1;
                    rs1_sel   = 1'b0;
                end else begin
                    // vsetvli/vsetvl with rs1=rd=x0 keeps vl, so no rs1/rd operand.
                    vl_sel    = 1'b0;
                    vtype_sel = !q_vsetvl;
                    rs1rd_de  = !q_x0;
                    rs1_sel   = q_x0;
                end
            end
            LD_REQ, LD_WAIT: begin
                ld_req = (state == LD_REQ);
                case (q_mop)
                    MOP_UNIT: begin
                        lumop_sel = 1'b1;
                        vtype_sel = 1'b1;
                    end
                    MOP_STRIDED: begin
                        lumop_sel = 1'b0;
                        vtype_sel = 1'b0;
                    end
                    default: begin
                        vtype_sel = 1'b1;
                        vs2_sel   = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed scoreboard bench for vec_issue_ctrl: every cycle's expected outputs are
// queued with the stimulus and compared one clock later.
module tb_vec_issue_ctrl;

    localparam int XLEN  = 32;
    localparam int TMO_W = 4;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

    typedef struct packed {
        logic inst_ready;
        logic busy;
        logic vl_sel;
        logic vtype_sel;
        logic rs1rd_de;
        logic lumop_sel;
        logic rs1_sel;
        logic vs2_sel;
        logic csrwr_en;
        logic ld_req;
        logic illegal_inst;
        logic timeout_err;
    } outs_t;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] vec_inst;
    logic            inst_valid;
    logic            inst_ready;
    logic            vl_sel;
    logic            vtype_sel;
    logic            rs1rd_de;
    logic            lumop_sel;
    logic            rs1_sel;
    logic            vs2_sel;
    logic            csrwr_en;
    logic            ld_req;
    logic            ld_done;
    logic            busy;
    logic            illegal_inst;
    logic            timeout_err;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_cmp;
    int    n_fail;
    int    busy_acc;

    vec_issue_ctrl #(.XLEN(XLEN), .TMO_W(TMO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .vec_inst     (vec_inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .vl_sel       (vl_sel),
        .vtype_sel    (vtype_sel),
        .rs1rd_de     (rs1rd_de),
        .lumop_sel    (lumop_sel),
        .rs1_sel      (rs1_sel),
        .vs2_sel      (vs2_sel),
        .csrwr_en     (csrwr_en),
        .ld_req       (ld_req),
        .ld_done      (ld_done),
        .busy         (busy),
        .illegal_inst (illegal_inst),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t f_idle(input logic ill, input logic tmo);
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ill, tmo};
    endfunction

    function automatic outs_t f_conf(input logic vl, input logic vt, input logic de, input logic r1);
        return {1'b0, 1'b1, vl, vt, de, 1'b0, r1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic outs_t f_load(input logic [1:0] mop, input logic req);
        logic lu, vt, v2;
        case (mop)
            2'b00:   begin lu = 1'b1; vt = 1'b1; v2 = 1'b0; end
            2'b10:   begin lu = 1'b0; vt = 1'b0; v2 = 1'b0; end
            default: begin lu = 1'b0; vt = 1'b1; v2 = 1'b1; end
        endcase
        return {1'b0, 1'b1, 1'b0, vt, 1'b1, lu, 1'b1, v2, 1'b0, req, 1'b0, 1'b0};
    endfunction

    task automatic check_output();
        outs_t obs;
        outs_t e;
        string t;
        obs = {inst_ready, busy, vl_sel, vtype_sel, rs1rd_de, lumop_sel,
               rs1_sel, vs2_sel, csrwr_en, ld_req, illegal_inst, timeout_err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (obs.busy) busy_acc++;
        assert (obs === e) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    // Queue the expectation for the cycle after the next edge, then compare it.
    task automatic apply_stimulus(input string tag, input outs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic check_now(input string tag, input outs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_output();
    endtask

    logic [31:0] i_vsetvli_x5;
    logic [31:0] i_vsetvl_x0;
    logic [31:0] i_vsetivli;
    logic [31:0] i_vsetvli_x0;
    logic [31:0] i_ld_unit;
    logic [31:0] i_ld_idx_ord;
    logic [31:0] i_ld_idx_unord;
    logic [31:0] i_ld_strided;
    logic [31:0] i_add;
    logic [31:0] i_vec_f3_0;
    logic [31:0] i_ld_bad_w;

    initial begin
        i_vsetvli_x5   = {1'b0, 11'h010, 5'd5, 3'b111, 5'd6, 7'b1010111};
        i_vsetvl_x0    = {7'b1000000, 5'd7, 5'd0, 3'b111, 5'd0, 7'b1010111};
        i_vsetivli     = {2'b11, 10'h010, 5'd4, 3'b111, 5'd3, 7'b1010111};
        i_vsetvli_x0   = {1'b0, 11'h010, 5'd0, 3'b111, 5'd0, 7'b1010111};
        i_ld_unit      = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b110, 5'd8, 7'b0000111};
        i_ld_idx_ord   = {3'b000, 1'b0, 2'b11, 1'b1, 5'd4, 5'd10, 3'b000, 5'd8, 7'b0000111};
        i_ld_idx_unord = {3'b000, 1'b0, 2'b01, 1'b1, 5'd4, 5'd11, 3'b111, 5'd9, 7'b0000111};
        i_ld_strided   = {3'b000, 1'b0, 2'b10, 1'b1, 5'd2, 5'd12, 3'b101, 5'd8, 7'b0000111};
        i_add          = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        i_vec_f3_0     = {6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1010111};
        i_ld_bad_w     = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b001, 5'd8, 7'b0000111};

        n_cmp = 0;
        n_fail = 0;
        busy_acc = 0;
        reset = 1'b1;
        inst_valid = 1'b1;
        vec_inst = i_vsetvli_x5;
        ld_done = 1'b0;

        // Reset outranks a valid instruction presented in the same cycle.
        apply_stimulus("reset_prio", f_idle(1'b0, 1'b0));
        inst_valid = 1'b0;
        apply_stimulus("reset_idle", f_idle(1'b0, 1'b0));
        reset = 1'b0;

        inst_valid = 1'b1;
        vec_inst = i_vsetvli_x5;
        apply_stimulus("vsetvli_conf", f_conf(1'b0, 1'b1, 1'b1, 1'b0));
        inst_valid = 1'b0;
        vec_inst = i_vsetvl_x0;
        #1;
        check_now("vsetvli_latched", f_conf(1'b0, 1'b1, 1'b1, 1'b0));
        apply_stimulus("vsetvli_idle", f_idle(1'b0, 1'b0));

        inst_valid = 1'b1;
        vec_inst = i_vsetvl_x0;
        apply_stimulus("vsetvl_x0_conf", f_conf(1'b0, 1'b0, 1'b0, 1'b1));
        inst_valid = 1'b0;
        apply_stimulus("vsetvl_idle", f_idle(1'b0, 1'b0));

        // Back-to-back: the second word waits through CONF and is taken from IDLE.
        inst_valid = 1'b1;
        vec_inst = i_vsetivli;
        apply_stimulus("vsetivli_conf", f_conf(1'b1, 1'b1, 1'b1, 1'b0));
        vec_inst = i_vsetvli_x0;
        apply_stimulus("b2b_idle_gap", f_idle(1'b0, 1'b0));
        apply_stimulus("vsetvli_x0_conf", f_conf(1'b0, 1'b1, 1'b0, 1'b1));
        inst_valid = 1'b0;
        apply_stimulus("b2b_idle", f_idle(1'b0, 1'b0));

        ld_done = 1'b1;
        apply_stimulus("done_in_idle", f_idle(1'b0, 1'b0));
        ld_done = 1'b0;

        busy_acc = 0;
        inst_valid = 1'b1;
        vec_inst = i_ld_unit;
        apply_stimulus("unit_ld_req", f_load(2'b00, 1'b1));
        inst_valid = 1'b0;
        for (int i = 0; i < 6; i++) apply_stimulus("unit_ld_wait", f_load(2'b00, 1'b0));
        ld_done = 1'b1;
        apply_stimulus("unit_ld_done", f_idle(1'b0, 1'b0));
        ld_done = 1'b0;
        n_cmp++;
        assert (busy_acc === 1 + 6) else begin
            n_fail++;
            $error("[TB] FAIL unit_busy_cycles: observed %0d expected %0d", busy_acc, 1 + 6);
        end

        // Watchdog: TMO_MAX LD_WAIT cycles then a one-cycle error; ld_done in LD_REQ is ignored.
        inst_valid = 1'b1;
        vec_inst = i_ld_idx_ord;
        apply_stimulus("idx_ld_req", f_load(2'b11, 1'b1));
        inst_valid = 1'b0;
        ld_done = 1'b1;
        apply_stimulus("idx_done_in_req", f_load(2'b11, 1'b0));
        ld_done = 1'b0;
        for (int i = 1; i < TMO_MAX; i++) apply_stimulus("idx_ld_wait", f_load(2'b11, 1'b0));
        apply_stimulus("idx_timeout", f_idle(1'b0, 1'b1));
        apply_stimulus("idx_timeout_pulse", f_idle(1'b0, 1'b0));

        inst_valid = 1'b1;
        vec_inst = i_ld_idx_unord;
        apply_stimulus("race_ld_req", f_load(2'b01, 1'b1));
        inst_valid = 1'b0;
        for (int i = 0; i < TMO_MAX; i++) apply_stimulus("race_ld_wait", f_load(2'b01, 1'b0));
        ld_done = 1'b1;
        apply_stimulus("race_done_wins", f_idle(1'b0, 1'b0));
        ld_done = 1'b0;
        apply_stimulus("race_no_tmo", f_idle(1'b0, 1'b0));

        inst_valid = 1'b1;
        vec_inst = i_add;
        apply_stimulus("illegal_add", f_idle(1'b1, 1'b0));
        vec_inst = i_vec_f3_0;
        apply_stimulus("illegal_vec_f3", f_idle(1'b1, 1'b0));
        vec_inst = i_ld_bad_w;
        apply_stimulus("illegal_ld_width", f_idle(1'b1, 1'b0));
        inst_valid = 1'b0;
        apply_stimulus("illegal_pulse", f_idle(1'b0, 1'b0));

        // Reset lands on the very edge that would otherwise raise timeout_err.
        inst_valid = 1'b1;
        vec_inst = i_ld_strided;
        apply_stimulus("str_ld_req", f_load(2'b10, 1'b1));
        inst_valid = 1'b0;
        for (int i = 0; i < TMO_MAX; i++) apply_stimulus("str_ld_wait", f_load(2'b10, 1'b0));
        reset = 1'b1;
        apply_stimulus("str_reset_abort", f_idle(1'b0, 1'b0));
        reset = 1'b0;
        apply_stimulus("str_after_reset", f_idle(1'b0, 1'b0));

        inst_valid = 1'b1;
        vec_inst = i_vsetvli_x5;
        apply_stimulus("post_reset_conf", f_conf(1'b0, 1'b1, 1'b1, 1'b0));
        inst_valid = 1'b0;
        apply_stimulus("post_reset_idle", f_idle(1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
